// File: rtl/instr_fetch_responder_if.sv
// Instruction-fetch bus between a CPU (master) and the fetch responder (slave).
// Carries the request handshake and the one-cycle response.
interface instr_fetch_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata,
    output err
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: word memory with a backdoor load port and a fixed-latency fetch FSM.
// Optional macro IFETCH_ERR_CHECK_EN flags misaligned/out-of-range fetches through err.
module instr_fetch_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  instr_fetch_responder_if.slave bus,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT     = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);
  localparam bit         LAT_ZERO = (LATENCY == 0);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           addr_p0;
  logic [31:0]           data_p1;
  logic                  err_p1;
  logic                  rvalid_p2;
  logic [31:0]           rdata_p2;
  logic                  err_p2;

  logic                  accept;
  logic                  resp_entry;
  logic [31:0]           fetch_addr;
  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic [31:0]           mem_rd;
  logic                  fetch_err;

`ifdef IFETCH_ERR_CHECK_EN
  function automatic logic addr_fault(input logic [31:0] a);
    addr_fault = (a[1:0] != 2'b00) || (a[31:DEPTH_LOG2+2] != '0);
  endfunction

  assign fetch_err = addr_fault(fetch_addr);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:DEPTH_LOG2+2], fetch_addr[1:0]};
  assign fetch_err        = 1'b0;
`endif

  assign accept     = (state == IDLE) && bus.req;
  assign resp_entry = (accept && LAT_ZERO) || ((state == WAIT) && (wait_cnt <= 4'd1));

  // With zero latency the read happens on the accepting edge, so the live address is used.
  assign fetch_addr = (state == IDLE) ? bus.addr : addr_p0;
  assign fetch_idx  = fetch_addr[DEPTH_LOG2+1:2];
  assign mem_rd     = (load_en && (load_addr == fetch_idx)) ? load_data : mem[fetch_idx];

  assign bus.ready  = (state == IDLE);
  assign bus.rvalid = rvalid_p2;
  assign bus.rdata  = rdata_p2;
  assign bus.err    = err_p2;

  always_ff @(posedge clock) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // p0: address capture at acceptance
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0 <= bus.addr;
    end
  end

  // p1: word read at RESP entry
  always_ff @(posedge clock) begin
    if (resp_entry) begin
      data_p1 <= fetch_err ? 32'h0 : mem_rd;
      err_p1  <= fetch_err;
    end
  end

  // p2: response registers; rdata is part of the reset state and holds between responses
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rvalid_p2 <= 1'b0;
      err_p2    <= 1'b0;
      rdata_p2  <= 32'h0;
    end else begin
      rvalid_p2 <= 1'b0;
      err_p2    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            wait_cnt <= LAT_INIT;
            state    <= LAT_ZERO ? RESP : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state     <= IDLE;
          rvalid_p2 <= 1'b1;
          rdata_p2  <= data_p1;
          err_p2    <= err_p1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: a LATENCY=0 and a LATENCY=2 instance share one stimulus
// stream and are checked every cycle against a cycle-count based fetch model.
module tb_instr_fetch_responder;
  localparam int DL = 6;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic [31:0]   addr;
  logic          load_en;
  logic [DL-1:0] load_addr;
  logic [31:0]   load_data;

  int nchk = 0;
  int nerr = 0;
  bit cmp_en = 0;

  instr_fetch_responder_if if_l0 ();
  instr_fetch_responder_if if_l2 ();

  assign if_l0.req  = req;
  assign if_l0.addr = addr;
  assign if_l2.req  = req;
  assign if_l2.addr = addr;

  instr_fetch_responder #(.DEPTH_LOG2(DL), .LATENCY(0)) u_dut_l0 (
    .clock(clk), .reset(rst_n), .bus(if_l0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  instr_fetch_responder #(.DEPTH_LOG2(DL), .LATENCY(2)) u_dut_l2 (
    .clock(clk), .reset(rst_n), .bus(if_l2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  logic        act_rdy [2];
  logic        act_rv  [2];
  logic [31:0] act_rd  [2];
  logic        act_er  [2];
  assign act_rdy[0] = if_l0.ready;  assign act_rdy[1] = if_l2.ready;
  assign act_rv[0]  = if_l0.rvalid; assign act_rv[1]  = if_l2.rvalid;
  assign act_rd[0]  = if_l0.rdata;  assign act_rd[1]  = if_l2.rdata;
  assign act_er[0]  = if_l0.err;    assign act_er[1]  = if_l2.err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // Fetch model: a request accepted at edge e is read at edge e+LAT and answered after edge e+LAT+1
  int          lat_m  [2] = '{0, 2};
  bit          busy_m [2];
  int          acc_m  [2];
  logic [31:0] la_m   [2];
  logic [31:0] res_d  [2];
  logic        res_e  [2];
  logic        exp_rdy[2];
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
  logic        exp_er [2];
  logic [31:0] mem_m  [1<<DL];
  int          ecnt;

  initial begin
    bit            idle_b;
    logic [DL-1:0] idx;
    ecnt = 0;
    for (int d = 0; d < 2; d++) begin
      busy_m[d] = 0; acc_m[d] = 0; exp_rdy[d] = 1; exp_rv[d] = 0; exp_rd[d] = 0; exp_er[d] = 0;
    end
    forever begin
      @(posedge clk);
      ecnt++;
      for (int d = 0; d < 2; d++) begin
        idle_b = !busy_m[d];
        if (!rst_n) begin
          busy_m[d] = 0; exp_rv[d] = 0; exp_er[d] = 0; exp_rd[d] = 32'h0;
        end else begin
          exp_rv[d] = 0;
          exp_er[d] = 0;
          if (busy_m[d] && ecnt == acc_m[d] + lat_m[d] + 1) begin
            exp_rv[d] = 1; exp_rd[d] = res_d[d]; exp_er[d] = res_e[d]; busy_m[d] = 0;
          end
          if (idle_b && req) begin
            busy_m[d] = 1; acc_m[d] = ecnt; la_m[d] = addr;
          end
          if (busy_m[d] && ecnt == acc_m[d] + lat_m[d]) begin
            idx      = la_m[d][DL+1:2];
            res_d[d] = (load_en && load_addr == idx) ? load_data : mem_m[idx];
            res_e[d] = 1'b0;
`ifdef IFETCH_ERR_CHECK_EN
            res_e[d] = (la_m[d][1:0] != 2'b00) || (la_m[d] >= 32'(4 * (1 << DL)));
            if (res_e[d]) res_d[d] = 32'h0;
`endif
          end
        end
        exp_rdy[d] = !busy_m[d];
      end
      if (load_en) mem_m[load_addr] = load_data;
    end
  end

  int          rv_cnt [2] = '{0, 0};
  logic [31:0] last_rd[2];

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int d = 0; d < 2; d++) begin
          chk("ready",  d, 32'(act_rdy[d]), 32'(exp_rdy[d]));
          chk("rvalid", d, 32'(act_rv[d]),  32'(exp_rv[d]));
          chk("rdata",  d, act_rd[d],       exp_rd[d]);
          chk("err",    d, 32'(act_er[d]),  32'(exp_er[d]));
          if (act_rv[d] === 1'b1) begin
            rv_cnt[d]++;
            last_rd[d] = act_rd[d];
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rv(input int d, input int maxc, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (act_rv[d] !== 1'b1 && k < maxc);
    if (act_rv[d] !== 1'b1) begin
      nchk++;
      nerr++;
      $display("FAIL rvalid_timeout dut%0d: no rvalid within %0d cycles", d, maxc);
    end
  endtask

  task automatic load(input int a, input logic [31:0] v);
    load_en = 1'b1; load_addr = DL'(a); load_data = v;
    step(1);
  endtask

  initial begin
    int k;
    int snap0;
    int snap1;
    rst_n = 1'b0; req = 1'b0; addr = 32'h0;
    load_en = 1'b0; load_addr = '0; load_data = 32'h0;
    step(1);
    cmp_en = 1'b1;

    // program load while held in reset
    for (int i = 0; i < (1 << DL); i++) load(i, {8'h5A, 8'(i), 8'(~i), 8'(i * 3)});
    load(0, 32'h00611000);
    load(1, 32'hA5A5A5A5);
    load(3, 32'h00000001);
    load(4, 32'h44444444);
    load(5, 32'h55555555);
    load_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready",  d, 32'(act_rdy[d]), 32'h1);
      chk("reset_rvalid", d, 32'(act_rv[d]),  32'h0);
      chk("reset_rdata",  d, act_rd[d],       32'h0);
    end
    rst_n = 1'b1;
    step(1);

    // basic fetch, LATENCY=2
    req = 1'b1; addr = 32'h0;
    wait_rv(1, 10, k);
    req = 1'b0;
    chk("lat2_cycles", 1, 32'(k - 1), 32'd3);
    chk("lat2_rdata",  1, act_rd[1],  32'h00611000);
    chk("lat2_err",    1, 32'(act_er[1]), 32'h0);
    step(4);

    // LATENCY=0 with req held: back-to-back fetches
    req = 1'b1; addr = 32'h4;
    wait_rv(0, 10, k);
    chk("lat0_cycles", 0, 32'(k), 32'd2);
    chk("lat0_rdata",  0, act_rd[0], 32'hA5A5A5A5);
    wait_rv(0, 10, k);
    chk("lat0_b2b_gap",   0, 32'(k), 32'd2);
    chk("lat0_b2b_rdata", 0, act_rd[0], 32'hA5A5A5A5);
    wait_rv(1, 10, k);
    req = 1'b0;
    step(4);

    // out-of-range and misaligned addresses
    req = 1'b1; addr = 32'h100;
    wait_rv(1, 10, k);
    req = 1'b0;
`ifdef IFETCH_ERR_CHECK_EN
    chk("oor_err",   1, 32'(act_er[1]), 32'h1);
    chk("oor_rdata", 1, act_rd[1],      32'h0);
`else
    chk("wrap_err",   1, 32'(act_er[1]), 32'h0);
    chk("wrap_rdata", 1, act_rd[1],      32'h00611000);
`endif
    step(3);
    req = 1'b1; addr = 32'h2;
    wait_rv(1, 10, k);
    req = 1'b0;
`ifdef IFETCH_ERR_CHECK_EN
    chk("misalign_err",   1, 32'(act_er[1]), 32'h1);
    chk("misalign_rdata", 1, act_rd[1],      32'h0);
`else
    chk("misalign_err",   1, 32'(act_er[1]), 32'h0);
    chk("misalign_rdata", 1, act_rd[1],      32'h00611000);
`endif
    step(3);

    // reset during WAIT aborts the fetch
    load(2, 32'h22222222);
    load_en = 1'b0;
    req = 1'b1; addr = 32'h8;
    step(1);
    req = 1'b0; rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("abort_ready",  1, 32'(act_rdy[1]), 32'h1);
    chk("abort_rvalid", 1, 32'(act_rv[1]),  32'h0);
    chk("abort_rdata",  1, act_rd[1],       32'h0);
    snap0 = rv_cnt[0]; snap1 = rv_cnt[1];
    step(7);
    chk("abort_no_rvalid", 1, 32'(rv_cnt[1] - snap1), 32'h0);
    chk("abort_no_rvalid", 0, 32'(rv_cnt[0] - snap0), 32'h0);

    // load during WAIT is visible
    req = 1'b1; addr = 32'hC;
    step(1);
    req = 1'b0; load_en = 1'b1; load_addr = 6'd3; load_data = 32'hDEADBEEF;
    step(1);
    load_en = 1'b0;
    wait_rv(1, 10, k);
    chk("wait_load_cycles", 1, 32'(k), 32'd2);
    chk("wait_load_rdata",  1, act_rd[1], 32'hDEADBEEF);
    step(3);

    // load on the RESP-entry edge is seen, load one edge later is not
    req = 1'b1; addr = 32'hC;
    step(1);
    req = 1'b0;
    step(1);
    load_en = 1'b1; load_addr = 6'd3; load_data = 32'hCAFEF00D;
    step(1);
    load_data = 32'h0BADF00D;
    wait_rv(1, 10, k);
    load_en = 1'b0;
    chk("entry_load_cycles", 1, 32'(k), 32'd1);
    chk("entry_load_rdata",  1, act_rd[1], 32'hCAFEF00D);
    step(3);

    // stray req pulses and addr changes while busy
    snap1 = rv_cnt[1];
    req = 1'b1; addr = 32'h10;
    step(1);
    req = 1'b0; addr = 32'h14;
    step(1);
    req = 1'b1; addr = 32'h14;
    step(1);
    addr = 32'h18;
    step(1);
    req = 1'b0;
    step(6);
    chk("stray_one_rvalid", 1, 32'(rv_cnt[1] - snap1), 32'h1);
    chk("stray_rdata",      1, last_rd[1], 32'h44444444);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
